cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) between NUM_FU functional units: ALU, mul/div, load/store.
- Each unit presents a CDB packet: valid, ROB id, physical rd, architectural rd, data.
- Round-robin pick of one packet per cycle, registered onto the CDB. One holding slot per unit absorbs a lost arbitration. A unit is stalled only when its slot is still occupied.
- Sits between the functional-unit output registers and the ROB / reservation-station / regfile CDB listeners.

---
 rtl/module_types.sv | 23 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/cdb_arbiter.sv | 122 ++++++++++++
 tb/tb_cdb_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/module_types.sv
// Shared types and sizing for the CDB arbiter and its round-robin picker.
package module_types;

   localparam int NUM_FU    = 3;
   localparam int ROB_IDX_W = 5;
   localparam int PHYS_W    = 6;
   localparam int ARCH_W    = 5;
   localparam int DATA_W    = 32;
   localparam int FU_IDX_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

   typedef struct packed {
      logic [ROB_IDX_W-1:0] rob_id;
      logic [PHYS_W-1:0]    phys_rd;
      logic [ARCH_W-1:0]    arch_rd;
      logic [DATA_W-1:0]    data;
   } cdb_pkt_t;

   // Successor of a unit index, wrapping from the last unit back to unit 0.
   function automatic logic [FU_IDX_W-1:0] nextIdx(input logic [FU_IDX_W-1:0] idx);
      return (int'(idx) == NUM_FU - 1) ? '0 : idx + 1'b1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after ptr_i wins.
// Also intended for reuse in the issue-select logic.
module rr_arbiter #(
   parameter  int N  = 3,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  grant_o,
   output logic [IW-1:0] winner_o
);

   logic [IW-1:0] idx;

   // Scanning from the far end means the requester nearest ptr_i is written last and wins.
   always_comb begin
      grant_o  = '0;
      winner_o = '0;
      idx      = '0;
      for (int off = N - 1; off >= 0; off--) begin
         idx = IW'((int'(ptr_i) + off) % N);
         if (req_i[idx]) begin
            grant_o      = '0;
            grant_o[idx] = 1'b1;
            winner_o     = idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter with one holding slot per functional unit.
// Define CDB_ARB_PERF_EN to add saturating conflict/stall performance counters.
module cdb_arbiter
   import module_types::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic [NUM_FU-1:0] fu_valid,
   input  cdb_pkt_t          fu_pkt [NUM_FU],
   output logic [NUM_FU-1:0] fu_stall,
   output logic              cdb_valid,
   output cdb_pkt_t          cdb_pkt
`ifdef CDB_ARB_PERF_EN
   ,
   output logic [31:0]       perf_conflict_cnt,
   output logic [31:0]       perf_stall_cnt
`endif
);

   logic [NUM_FU-1:0]   hold_vld_q, hold_vld_d;
   cdb_pkt_t            hold_pkt_q [NUM_FU];
   cdb_pkt_t            hold_pkt_d [NUM_FU];
   logic [FU_IDX_W-1:0] rr_ptr_q, rr_ptr_d;
   logic                cdb_valid_q, cdb_valid_d;
   cdb_pkt_t            cdb_pkt_q, cdb_pkt_d;
   logic [NUM_FU-1:0]   req, grant;
   logic [FU_IDX_W-1:0] winner;
   cdb_pkt_t            cand [NUM_FU];

   // A held packet is always older than the live one, so it is offered first.
   always_comb begin
      req = hold_vld_q | fu_valid;
      for (int i = 0; i < NUM_FU; i++) begin
         cand[i] = hold_vld_q[i] ? hold_pkt_q[i] : fu_pkt[i];
      end
   end

   rr_arbiter #(.N(NUM_FU)) u_rr (
      .req_i    (req),
      .ptr_i    (rr_ptr_q),
      .grant_o  (grant),
      .winner_o (winner)
   );

   assign fu_stall  = hold_vld_q & ~grant;
   assign cdb_valid = cdb_valid_q;
   assign cdb_pkt   = cdb_pkt_q;

   always_comb begin
      hold_vld_d  = hold_vld_q;
      hold_pkt_d  = hold_pkt_q;
      cdb_valid_d = |grant;
      cdb_pkt_d   = cdb_pkt_q;
      rr_ptr_d    = rr_ptr_q;
      if (|grant) begin
         cdb_pkt_d = cand[winner];
         rr_ptr_d  = nextIdx(winner);
      end
      for (int i = 0; i < NUM_FU; i++) begin
         if (grant[i]) begin
            // Draining the slot frees room for whatever the unit presents this cycle.
            if (hold_vld_q[i]) begin
               hold_vld_d[i] = fu_valid[i];
               if (fu_valid[i]) begin
                  hold_pkt_d[i] = fu_pkt[i];
               end
            end
         end else if (!hold_vld_q[i] && fu_valid[i]) begin
            hold_vld_d[i] = 1'b1;
            hold_pkt_d[i] = fu_pkt[i];
         end
      end
      if (flush) begin
         cdb_valid_d = 1'b0;
         cdb_pkt_d   = cdb_pkt_q;
         hold_vld_d  = '0;
         rr_ptr_d    = rr_ptr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_vld_q  <= '0;
         rr_ptr_q    <= '0;
         cdb_valid_q <= 1'b0;
         cdb_pkt_q   <= '0;
         for (int i = 0; i < NUM_FU; i++) begin
            hold_pkt_q[i] <= '0;
         end
      end else begin
         hold_vld_q  <= hold_vld_d;
         hold_pkt_q  <= hold_pkt_d;
         rr_ptr_q    <= rr_ptr_d;
         cdb_valid_q <= cdb_valid_d;
         cdb_pkt_q   <= cdb_pkt_d;
      end
   end

`ifdef CDB_ARB_PERF_EN
   logic [31:0] perf_conflict_q, perf_stall_q;

   // Counters keep running through flush; only reset clears them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_conflict_q <= '0;
         perf_stall_q    <= '0;
      end else begin
         if ($countones(req) >= 2 && perf_conflict_q != '1) begin
            perf_conflict_q <= perf_conflict_q + 32'd1;
         end
         if (|fu_stall && perf_stall_q != '1) begin
            perf_stall_q <= perf_stall_q + 32'd1;
         end
      end
   end

   assign perf_conflict_cnt = perf_conflict_q;
   assign perf_stall_cnt    = perf_stall_q;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model plus directed literal checks.
// Build with CDB_ARB_PERF_EN defined to also exercise the performance counters.
module tb_cdb_arbiter;
   import module_types::*;

   logic              clk;
   logic              rst_n;
   logic              flush;
   logic [NUM_FU-1:0] fu_valid;
   cdb_pkt_t          fu_pkt [NUM_FU];
   logic [NUM_FU-1:0] fu_stall;
   logic              cdb_valid;
   cdb_pkt_t          cdb_pkt;
`ifdef CDB_ARB_PERF_EN
   logic [31:0]       perf_conflict_cnt;
   logic [31:0]       perf_stall_cnt;
`endif

   int nCompared   = 0;
   int nMismatched = 0;
   bit cmpEn       = 0;

   cdb_pkt_t src  [NUM_FU][$];
   cdb_pkt_t slot [NUM_FU][$];
   int       mPtr  = 0;
   bit       mVld  = 0;
   cdb_pkt_t mPkt  = '0;
   logic [31:0] mConf = '0;
   logic [31:0] mStc  = '0;

   cdb_arbiter dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .fu_valid  (fu_valid),
      .fu_pkt    (fu_pkt),
      .fu_stall  (fu_stall),
      .cdb_valid (cdb_valid),
      .cdb_pkt   (cdb_pkt)
`ifdef CDB_ARB_PERF_EN
      ,
      .perf_conflict_cnt (perf_conflict_cnt),
      .perf_stall_cnt    (perf_stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit bitOf(input logic [NUM_FU-1:0] v, input int u);
      logic [NUM_FU-1:0] t;
      t = v >> u;
      return t[0];
   endfunction

   function automatic cdb_pkt_t mkPkt(input int rob, input logic [31:0] data);
      cdb_pkt_t p;
      p.rob_id  = ROB_IDX_W'(rob);
      p.phys_rd = PHYS_W'(rob + 1);
      p.arch_rd = ARCH_W'(rob % 32);
      p.data    = data;
      return p;
   endfunction

   // Reference: whoever has something (held or live) nearest the pointer owns the bus.
   function automatic int pickWinner();
      for (int k = 0; k < NUM_FU; k++) begin
         int u = (mPtr + k) % NUM_FU;
         if (slot[u].size() > 0 || bitOf(fu_valid, u)) return u;
      end
      return -1;
   endfunction

   function automatic logic [NUM_FU-1:0] expStall(input int win);
      logic [NUM_FU-1:0] s = '0;
      for (int u = 0; u < NUM_FU; u++) begin
         if (slot[u].size() > 0 && u != win) s = s | (NUM_FU'(1) << u);
      end
      return s;
   endfunction

   int                mWin;
   int                mReq;
   logic [NUM_FU-1:0] mStl;
   bit                mAcc [NUM_FU];

   // Model advances on the same edge as the DUT; it also retires packets from the unit sources.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int u = 0; u < NUM_FU; u++) slot[u].delete();
         mVld  = 0;
         mPkt  = '0;
         mPtr  = 0;
         mConf = '0;
         mStc  = '0;
      end else begin
         mWin = pickWinner();
         mStl = expStall(mWin);
         mReq = 0;
         for (int u = 0; u < NUM_FU; u++) begin
            if (slot[u].size() > 0 || bitOf(fu_valid, u)) mReq++;
         end
         if (mReq >= 2 && mConf != '1) mConf = mConf + 1;
         if (mStl != '0 && mStc != '1) mStc = mStc + 1;
         for (int u = 0; u < NUM_FU; u++) begin
            mAcc[u] = bitOf(fu_valid, u) && !bitOf(mStl, u);
            if (mAcc[u] && src[u].size() > 0) void'(src[u].pop_front());
         end
         if (flush) begin
            for (int u = 0; u < NUM_FU; u++) slot[u].delete();
            mVld = 0;
         end else begin
            mVld = (mWin >= 0);
            if (mWin >= 0) begin
               if (slot[mWin].size() > 0) begin
                  mPkt = slot[mWin].pop_front();
               end else begin
                  mPkt       = fu_pkt[mWin];
                  mAcc[mWin] = 0;
               end
               mPtr = (mWin + 1) % NUM_FU;
            end
            for (int u = 0; u < NUM_FU; u++) begin
               if (mAcc[u]) slot[u].push_back(fu_pkt[u]);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && cmpEn) begin
         checkOutput("model cdb_valid", 64'(cdb_valid), 64'(mVld));
         if (mVld) checkOutput("model cdb_pkt", 64'(cdb_pkt), 64'(mPkt));
         checkOutput("model fu_stall", 64'(fu_stall), 64'(expStall(pickWinner())));
`ifdef CDB_ARB_PERF_EN
         checkOutput("model perf_conflict", 64'(perf_conflict_cnt), 64'(mConf));
         checkOutput("model perf_stall", 64'(perf_stall_cnt), 64'(mStc));
`endif
      end
   end

   task automatic driveInputs();
      for (int u = 0; u < NUM_FU; u++) begin
         fu_valid[u] = (src[u].size() > 0);
         fu_pkt[u]   = (src[u].size() > 0) ? src[u][0] : '0;
      end
   endtask

   task automatic applyStimulus();
      @(posedge clk);
      #2;
      driveInputs();
   endtask

   task automatic doReset();
      rst_n = 0;
      flush = 0;
      for (int u = 0; u < NUM_FU; u++) src[u].delete();
      driveInputs();
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_n = 1;
   endtask

   task automatic fillUnits(input int n, input logic [31:0] base);
      for (int u = 0; u < NUM_FU; u++) begin
         for (int k = 0; k < n; k++) begin
            src[u].push_back(mkPkt(u * 8 + k, base + 32'(u * 256 + k)));
         end
      end
   endtask

   logic [31:0] got [$];
   logic [2:0]  rrStall [4]  = '{3'b100, 3'b011, 3'b110, 3'b101};
   logic [31:0] rrOrder [12] = '{32'hA000, 32'hA100, 32'hA200, 32'hA001, 32'hA101, 32'hA201,
                                 32'hA002, 32'hA102, 32'hA202, 32'hA003, 32'hA103, 32'hA203};
   int          seen;

   initial begin
      clk   = 0;
      rst_n = 0;
      flush = 0;
      fu_valid = '0;
      for (int u = 0; u < NUM_FU; u++) fu_pkt[u] = '0;
      doReset();
      cmpEn = 1;
      checkOutput("reset cdb_valid", 64'(cdb_valid), 64'(0));
      checkOutput("reset cdb_pkt", 64'(cdb_pkt), 64'(0));
      checkOutput("reset fu_stall", 64'(fu_stall), 64'(0));

      // Lone request from unit 1 reaches the bus one cycle later.
      src[1].push_back(mkPkt(7, 32'h1234));
      driveInputs();
      checkOutput("single stall before", 64'(fu_stall), 64'(0));
      applyStimulus();
      checkOutput("single stall after", 64'(fu_stall), 64'(0));
      @(negedge clk); #1;
      checkOutput("single cdb_valid", 64'(cdb_valid), 64'(1));
      checkOutput("single rob_id", 64'(cdb_pkt.rob_id), 64'(7));
      checkOutput("single data", 64'(cdb_pkt.data), 64'(32'h1234));
      applyStimulus();
      @(negedge clk); #1;
      checkOutput("single idle cdb_valid", 64'(cdb_valid), 64'(0));

      // Full three-way contention from a fresh pointer, including held-slot refill on unit 1.
      doReset();
      fillUnits(4, 32'hA000);
      driveInputs();
      got.delete();
      for (int e = 1; e <= 16; e++) begin
         applyStimulus();
         @(negedge clk); #1;
         if (e <= 4) checkOutput($sformatf("rr stall E%0d", e), 64'(fu_stall), 64'(rrStall[e-1]));
         if (cdb_valid) got.push_back(cdb_pkt.data);
      end
      checkOutput("rr packet count", 64'(got.size()), 64'(12));
      for (int i = 0; i < 12; i++) begin
         if (i < got.size()) checkOutput($sformatf("rr order %0d", i), 64'(got[i]), 64'(rrOrder[i]));
      end

      // Flush while slots are occupied and the bus is busy.
      doReset();
      fillUnits(4, 32'hB000);
      driveInputs();
      repeat (2) applyStimulus();
      flush = 1;
      @(negedge clk); #1;
      checkOutput("flush precond cdb_valid", 64'(cdb_valid), 64'(1));
      @(posedge clk); #2;
      flush = 0;
      for (int u = 0; u < NUM_FU; u++) src[u].delete();
      driveInputs();
      @(negedge clk); #1;
      checkOutput("flush cdb_valid", 64'(cdb_valid), 64'(0));
      checkOutput("flush fu_stall", 64'(fu_stall), 64'(0));
      seen = 0;
      repeat (4) begin
         applyStimulus();
         @(negedge clk); #1;
         if (cdb_valid) seen++;
      end
      checkOutput("flush nothing after", 64'(seen), 64'(0));

      // Asynchronous reset in the middle of contention.
      doReset();
      fillUnits(3, 32'hC000);
      driveInputs();
      repeat (3) applyStimulus();
      @(negedge clk); #2;
      rst_n = 0;
      #1;
      checkOutput("async rst cdb_valid", 64'(cdb_valid), 64'(0));
      checkOutput("async rst fu_stall", 64'(fu_stall), 64'(0));
      for (int u = 0; u < NUM_FU; u++) src[u].delete();
      driveInputs();
      @(posedge clk); #3;
      rst_n = 1;
      src[0].push_back(mkPkt(1, 32'hD000));
      src[2].push_back(mkPkt(17, 32'hD200));
      driveInputs();
      applyStimulus();
      @(negedge clk); #1;
      checkOutput("post rst first valid", 64'(cdb_valid), 64'(1));
      checkOutput("post rst first data", 64'(cdb_pkt.data), 64'(32'hD000));
      applyStimulus();
      @(negedge clk); #1;
      checkOutput("post rst second valid", 64'(cdb_valid), 64'(1));
      checkOutput("post rst second data", 64'(cdb_pkt.data), 64'(32'hD200));

`ifdef CDB_ARB_PERF_EN
      // Ten edges of two-way contention: every edge conflicts, stalls begin on the third.
      doReset();
      checkOutput("perf reset conflict", 64'(perf_conflict_cnt), 64'(0));
      checkOutput("perf reset stall", 64'(perf_stall_cnt), 64'(0));
      for (int k = 0; k < 12; k++) begin
         src[0].push_back(mkPkt(k, 32'hE000 + 32'(k)));
         src[1].push_back(mkPkt(8 + k, 32'hE100 + 32'(k)));
      end
      driveInputs();
      repeat (10) applyStimulus();
      @(negedge clk); #1;
      checkOutput("perf conflict 10", 64'(perf_conflict_cnt), 64'(10));
      checkOutput("perf stall 8", 64'(perf_stall_cnt), 64'(8));
      doReset();
      checkOutput("perf cleared conflict", 64'(perf_conflict_cnt), 64'(0));
      checkOutput("perf cleared stall", 64'(perf_stall_cnt), 64'(0));
`endif

      repeat (2) applyStimulus();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
